// File: rtl/f2i48_sched_pkg.sv
// rtl/f2i48_sched_pkg.sv - fp48 format constants, request/response types and the float->int conversion function.
package f2i48_sched_pkg;

    localparam int MSB  = 47;
    localparam int EMSB = 10;
    localparam int FMSB = 35;
    localparam int BIAS = 'h3FF;

    typedef struct packed {
        logic           op;
        logic [MSB:0]   a;
    } f2i_req_t;

    typedef struct packed {
        logic [MSB:0]   o;
        logic           ovf;
    } f2i_resp_t;

    // Rounds half away from zero; out-of-range values saturate and raise ovf.
    // Unsigned conversion of a negative value that rounds to nonzero gives 0 with ovf.
    function automatic f2i_resp_t f2i_convert(input logic op, input logic [MSB:0] a);
        logic            sgn;
        logic [EMSB:0]   ex;
        logic [FMSB+1:0] man;
        logic [5:0]      sh;
        logic [49:0]     t;
        logic [48:0]     mag;
        logic            big_exp;
        logic            tiny;
        f2i_resp_t       r;
        sgn     = a[MSB];
        ex      = a[MSB-1:FMSB+1];
        man     = {1'b1, a[FMSB:0]};
        big_exp = ex >= 11'(BIAS + 48);
        tiny    = ex < 11'(BIAS - 1);
        sh      = 6'(ex - 11'(BIAS - 1));
        // t holds the magnitude with one extra fraction bit for rounding
        t       = 50'((86'(man) << sh) >> 36);
        mag     = tiny ? '0 : 49'((t + 50'd1) >> 1);
        r.ovf   = 1'b0;
        r.o     = '0;
        if (op) begin
            if (big_exp || (!sgn && mag > 49'h7FFF_FFFF_FFFF) || (sgn && mag > 49'h8000_0000_0000)) begin
                r.ovf = 1'b1;
                r.o   = sgn ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
            end else begin
                r.o   = sgn ? 48'(-mag) : mag[47:0];
            end
        end else begin
            if (sgn && (big_exp || mag != '0)) begin
                r.ovf = 1'b1;
                r.o   = '0;
            end else if (big_exp || mag[48]) begin
                r.ovf = 1'b1;
                r.o   = '1;
            end else begin
                r.o   = mag[47:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/f2i48.sv
// rtl/f2i48.sv - fp48 to 48-bit integer converter; registered result, combinational overflow.
module f2i48
    import f2i48_sched_pkg::*;
(
    input  logic         clk,
    input  logic         ce,
    input  logic         op,
    input  logic [MSB:0] i,
    output logic [MSB:0] o,
    output logic         overflow
);

    f2i_resp_t res;

    always_comb begin
        res = f2i_convert(op, i);
    end

    assign overflow = res.ovf;

    // Not reset: the scheduler masks stale contents with its own valid bit.
    always_ff @(posedge clk) begin
        if (ce) begin
            o <= res.o;
        end
    end

endmodule

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter; searches from ptr upward, one-hot grant plus binary index.
module rr_arb #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/f2i48_sched.sv
// rtl/f2i48_sched.sv - shares one f2i48 converter among NREQ requesters with round-robin arbitration.
module f2i48_sched
    import f2i48_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_op,
    input  logic [NREQ*48-1:0] req_a,
    output logic [NREQ-1:0]    req_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [MSB:0]       resp_o,
    output logic               resp_ovf,
    output logic [CNTW-1:0]    ovf_cnt,
    input  logic               ovf_clr
);

    f2i_req_t       reqs [NREQ];
    logic           v1;
    logic           v2;
    logic [MSB:0]   a_r;
    logic           op_r;
    logic [IDW-1:0] id_r;
    logic [IDW-1:0] id2_r;
    logic           ovf_r;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_idx;
    logic           ce;
    logic           s1_free;
    logic           grant;
    logic [MSB:0]   cv_o;
    logic           cv_ovf;

    always_comb begin
        for (int n = 0; n < NREQ; n++) begin
            reqs[n].op = req_op[n];
            reqs[n].a  = req_a[48*n +: 48];
        end
    end

    assign ce      = v1 & (~v2 | resp_ready);
    assign s1_free = ~v1 | ce;
    assign grant   = |(req_valid & req_ready);

    rr_arb #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (s1_free),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    f2i48 u_cvt (
        .clk      (clk),
        .ce       (ce),
        .op       (op_r),
        .i        (a_r),
        .o        (cv_o),
        .overflow (cv_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            rr_ptr <= '0;
            id2_r  <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (grant) begin
                a_r    <= reqs[gnt_idx].a;
                op_r   <= reqs[gnt_idx].op;
                id_r   <= gnt_idx;
                v1     <= 1'b1;
                rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (ce) begin
                v1 <= 1'b0;
            end
            // Overflow is combinational from the converter input, so capture it as S1 advances.
            if (ce) begin
                v2    <= 1'b1;
                ovf_r <= cv_ovf;
                id2_r <= id_r;
            end else if (resp_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            ovf_cnt <= '0;
        end else if (resp_valid && resp_ready && resp_ovf && !(&ovf_cnt)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    assign resp_valid = v2;
    assign resp_id    = v2 ? id2_r : '0;
    assign resp_o     = v2 ? cv_o : '0;
    assign resp_ovf   = v2 & ovf_r;

endmodule

// File: tb/tb_f2i48_sched.sv
// tb/tb_f2i48_sched.sv - directed self-checking bench for f2i48_sched.
module tb_f2i48_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    localparam logic [47:0] ONE   = 48'h3FF0_0000_0000;
    localparam logic [47:0] M3    = 48'hC008_0000_0000;
    localparam logic [47:0] BIG   = 48'h47FE_0000_0000;
    localparam logic [47:0] HALF  = 48'h3FE0_0000_0000;
    localparam logic [47:0] FOUR  = 48'h4010_0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_op;
    logic [NREQ*48-1:0] req_a;
    logic [NREQ-1:0]    req_ready;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [47:0]        resp_o;
    logic               resp_ovf;
    logic [CNTW-1:0]    ovf_cnt;
    logic               ovf_clr;
    logic [47:0]        a0, a1, a2, a3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign req_a = {a3, a2, a1, a0};

    f2i48_sched #(
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_o     (resp_o),
        .resp_ovf   (resp_ovf),
        .ovf_cnt    (ovf_cnt),
        .ovf_clr    (ovf_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic [1:0] id, input logic [47:0] o, input logic ovf);
        chk({tag, ".valid"}, 64'(resp_valid), 64'h1);
        chk({tag, ".id"},    64'(resp_id),    64'(id));
        chk({tag, ".o"},     64'(resp_o),     64'(o));
        chk({tag, ".ovf"},   64'(resp_ovf),   64'(ovf));
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_op = '0; resp_ready = 1'b1; ovf_clr = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        tick(); tick();
        chk("rst.resp_valid", 64'(resp_valid), 64'h0);
        chk("rst.resp_o",     64'(resp_o),     64'h0);
        chk("rst.resp_id",    64'(resp_id),    64'h0);
        chk("rst.resp_ovf",   64'(resp_ovf),   64'h0);
        chk("rst.ovf_cnt",    64'(ovf_cnt),    64'h0);
        chk("rst.req_ready",  64'(req_ready),  64'h0);
        rst = 1'b0;

        // 1) single conversion, latency two cycles
        req_valid = 4'b0001; req_op = 4'b0001; a0 = ONE; #1;
        chk("t1.ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0; #1;
        chk("t1.T+1.valid", 64'(resp_valid), 64'h0);
        tick();
        chk_resp("t1.resp", 2'd0, 48'd1, 1'b0);
        tick();
        chk("t1.drained", 64'(resp_valid), 64'h0);

        // 2) all four requesters, full throughput
        rst = 1'b1; tick(); rst = 1'b0;
        a0 = M3; a1 = M3; a2 = M3; a3 = M3; req_op = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            #1;
            chk("t2.ready", 64'(req_ready), (k < 5) ? 64'(1 << (k % 4)) : 64'h0);
            if (k >= 2 && k < 7) begin
                chk_resp("t2.resp", 2'((k - 2) % 4), 48'hFFFF_FFFF_FFFD, 1'b0);
            end else begin
                chk("t2.idle", 64'(resp_valid), 64'h0);
            end
            tick();
        end

        // 3) overflow, signed then unsigned
        req_valid = 4'b0010; req_op = 4'b0010; a1 = BIG; #1;
        chk("t3a.ready", 64'(req_ready), 64'h2);
        tick(); req_valid = '0; tick();
        chk_resp("t3a.resp", 2'd1, 48'h7FFF_FFFF_FFFF, 1'b1);
        tick();
        chk("t3a.ovf_cnt", 64'(ovf_cnt), 64'h1);
        req_valid = 4'b0100; req_op = 4'b0000; a2 = BIG; #1;
        chk("t3b.ready", 64'(req_ready), 64'h4);
        tick(); req_valid = '0; tick();
        chk_resp("t3b.resp", 2'd2, 48'hFFFF_FFFF_FFFF, 1'b1);
        tick();
        chk("t3b.ovf_cnt", 64'(ovf_cnt), 64'h2);

        // 4) backpressure with three requests, then drain
        resp_ready = 1'b0; req_op = 4'b0111; a0 = ONE; a1 = M3; a2 = FOUR;
        req_valid = 4'b0111; #1;
        chk("t4.g0", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0110; #1;
        chk("t4.g1", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4.full.ready", 64'(req_ready), 64'h0);
            chk_resp("t4.hold", 2'd0, 48'd1, 1'b0);
            tick();
        end
        resp_ready = 1'b1; #1;
        chk("t4.g2", 64'(req_ready), 64'h4);
        chk_resp("t4.d0", 2'd0, 48'd1, 1'b0);
        tick();
        req_valid = '0; #1;
        chk_resp("t4.d1", 2'd1, 48'hFFFF_FFFF_FFFD, 1'b0);
        tick();
        chk_resp("t4.d2", 2'd2, 48'd4, 1'b0);
        tick();
        chk("t4.empty", 64'(resp_valid), 64'h0);

        // 5) pointer wrap after requester 3
        req_op = 4'b1111; a3 = HALF; req_valid = 4'b1000; #1;
        chk("t5.g3", 64'(req_ready), 64'h8);
        tick();
        a0 = '0; a3 = '0; req_valid = 4'b1001; #1;
        chk("t5.wrap", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b1000; #1;
        chk("t5.g3b", 64'(req_ready), 64'h8);
        chk_resp("t5.r0", 2'd3, 48'd1, 1'b0);
        tick();
        req_valid = '0; #1;
        chk_resp("t5.r1", 2'd0, 48'd0, 1'b0);
        tick();
        chk_resp("t5.r2", 2'd3, 48'd0, 1'b0);
        tick();
        chk("t5.empty", 64'(resp_valid), 64'h0);

        // 6) reset while full, then saturation and clear
        resp_ready = 1'b0; a0 = BIG; a1 = BIG; a2 = BIG; a3 = BIG;
        req_valid = 4'b0001; tick();
        req_valid = 4'b0010; tick();
        req_valid = 4'b0100; #1;
        chk("t6.full.ready", 64'(req_ready), 64'h0);
        chk("t6.full.valid", 64'(resp_valid), 64'h1);
        chk("t6.pre.ovf_cnt", 64'(ovf_cnt), 64'h2);
        rst = 1'b1; tick();
        rst = 1'b0; req_valid = '0; #1;
        chk("t6.rst.valid", 64'(resp_valid), 64'h0);
        chk("t6.rst.ready", 64'(req_ready), 64'h0);
        chk("t6.rst.ovf_cnt", 64'(ovf_cnt), 64'h0);
        chk("t6.rst.resp_o", 64'(resp_o), 64'h0);
        resp_ready = 1'b1; req_valid = 4'b1111; #1;
        chk("t6.first", 64'(req_ready), 64'h1);
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        chk("t6.sat", 64'(ovf_cnt), 64'hFFFF);
        chk("t6.sat.ovf", 64'(resp_ovf), 64'h1);
        tick();
        chk("t6.sat.hold", 64'(ovf_cnt), 64'hFFFF);
        ovf_clr = 1'b1; #1;
        chk("t6.clr.ovf", 64'(resp_ovf), 64'h1);
        tick();
        ovf_clr = 1'b0; #1;
        chk("t6.clr", 64'(ovf_cnt), 64'h0);
        tick();
        chk("t6.after_clr", 64'(ovf_cnt), 64'h1);
        req_valid = '0;
        tick(); tick(); tick();
        chk("t6.drained", 64'(resp_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
